// File: rtl/mem_arbiter_if.sv
// Bundled native mem bus for mem_arbiter: NUM_M requesters on the upstream side, one slave downstream.
// The arbiter is the slave of the upstream masters and the master of the downstream slave.
interface mem_arbiter_if #(
  parameter int NUM_M = 2
);
  // Upstream (requester) side, master i in slice i
  logic [NUM_M-1:0]    m_valid;
  logic [NUM_M-1:0]    m_ready;
  logic [32*NUM_M-1:0] m_addr;
  logic [32*NUM_M-1:0] m_wdata;
  logic [4*NUM_M-1:0]  m_wstrb;
  logic [31:0]         m_rdata;

  // Downstream (slave) side
  logic                s_valid;
  logic                s_ready;
  logic [31:0]         s_addr;
  logic [31:0]         s_wdata;
  logic [3:0]          s_wstrb;
  logic [31:0]         s_rdata;

  // Arbiter facing the downstream slave
  modport master (
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  // Arbiter facing the upstream masters
  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: NUM_M-to-1 round-robin arbiter on the native mem bus, one registered grant cycle.
// Optional slave-response watchdog and sticky timeout_err enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int NUM_M          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  up,
  mem_arbiter_if.master dn,
  output logic          busy
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  if (NUM_M < 2 || NUM_M > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_arbiter: NUM_M must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic            s_valid_q, s_valid_d;

  logic [31:0]     addr_sl  [NUM_M];
  logic [31:0]     wdata_sl [NUM_M];
  logic [3:0]      wstrb_sl [NUM_M];

  logic            any_req;
  logic            hi_found;
  logic [IW-1:0]   hi_idx, lo_idx, pick;
  logic            done;
  logic            tmo_hit;
  logic [NUM_M-1:0] m_ready_vec;
  logic [31:0]     s_addr_mux, s_wdata_mux;
  logic [3:0]      s_wstrb_mux;

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_slice
    assign addr_sl[gi]  = up.m_addr[32*gi +: 32];
    assign wdata_sl[gi] = up.m_wdata[32*gi +: 32];
    assign wstrb_sl[gi] = up.m_wstrb[4*gi +: 4];
  end

  assign any_req = |up.m_valid;

  // Round-robin: lowest requester above last wins, otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (up.m_valid[i]) begin
        lo_idx = IW'(i);
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    pick = hi_found ? hi_idx : lo_idx;
  end

  assign done = (state_q == ST_BUSY) && (dn.s_ready || tmo_hit);

  // Bus outputs are zero unless a grant is held, so the slave never sees a stale address.
  always_comb begin
    s_addr_mux  = '0;
    s_wdata_mux = '0;
    s_wstrb_mux = '0;
    m_ready_vec = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (state_q == ST_BUSY && grant_q == IW'(i)) begin
        s_addr_mux     = addr_sl[i];
        s_wdata_mux    = wdata_sl[i];
        s_wstrb_mux    = wstrb_sl[i];
        m_ready_vec[i] = done;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_valid_d = s_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d   = pick;
          s_valid_d = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Requests from other masters are deliberately not looked at until the grant is released.
        if (done) begin
          last_d    = grant_q;
          s_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        s_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= IW'(NUM_M - 1);
      s_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      s_valid_q <= s_valid_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  // A real response in the same cycle as the limit takes precedence over the watchdog.
  assign tmo_hit = (state_q == ST_BUSY) && !dn.s_ready && (tmo_cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_cnt_d     = '0;
    timeout_err_d = timeout_err_q | tmo_hit;
    if (state_q == ST_BUSY && !done) begin
      tmo_cnt_d = tmo_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
  assign up.m_rdata  = tmo_hit ? 32'hDEADBEEF : dn.s_rdata;
`else
  assign tmo_hit    = 1'b0;
  assign up.m_rdata = dn.s_rdata;
`endif

  assign up.m_ready = m_ready_vec;
  assign dn.s_valid = s_valid_q;
  assign dn.s_addr  = s_addr_mux;
  assign dn.s_wdata = s_wdata_mux;
  assign dn.s_wstrb = s_wstrb_mux;
  assign busy       = (state_q == ST_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with two masters; timeout steps run when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int NUM_M = 2;

  logic clk;
  logic rstn;
  logic busy;
`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  mem_arbiter_if #(.NUM_M(NUM_M)) bus ();

  mem_arbiter #(
    .NUM_M          (NUM_M),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .up          (bus),
    .dn          (bus),
    .busy        (busy)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One granted transaction: waits (bounded) for s_valid, holds the slave for 'delay' cycles,
  // answers, then checks the mandatory idle gap.
  task automatic xact(input int g, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] rd, input int delay, input bit drop);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.s_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("grant_seen", 32'(bus.s_valid), 32'd1);
    for (int d = 0; d < delay; d++) begin
      chk("hold_valid", 32'(bus.s_valid), 32'd1);
      chk("hold_addr", bus.s_addr, addr);
      chk("hold_wdata", bus.s_wdata, wd);
      chk("hold_wstrb", 32'(bus.s_wstrb), 32'(ws));
      chk("hold_no_ready", 32'(bus.m_ready), 32'd0);
      @(negedge clk);
    end
    chk("s_addr", bus.s_addr, addr);
    chk("s_wdata", bus.s_wdata, wd);
    chk("s_wstrb", 32'(bus.s_wstrb), 32'(ws));
    chk("busy", 32'(busy), 32'd1);
    bus.s_ready = 1'b1;
    bus.s_rdata = rd;
    #1;
    chk("m_ready", 32'(bus.m_ready), 32'(1 << g));
    chk("m_rdata", bus.m_rdata, rd);
    next_cycle();
    bus.s_ready = 1'b0;
    if (drop) bus.m_valid[g] = 1'b0;
    @(negedge clk);
    chk("gap_s_valid", 32'(bus.s_valid), 32'd0);
    chk("gap_m_ready", 32'(bus.m_ready), 32'd0);
    chk("gap_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rstn        = 1'b0;
    bus.m_valid = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;

    // Reset state
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_s_valid", 32'(bus.s_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
    chk("rst_s_addr", bus.s_addr, 32'd0);
    chk("rst_s_wstrb", 32'(bus.s_wstrb), 32'd0);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
    next_cycle();
    rstn = 1'b1;

    // Single read with exact cycle timing
    bus.m_valid       = 2'b01;
    bus.m_addr[31:0]  = 32'h0000_0010;
    bus.m_wstrb[3:0]  = 4'h0;
    @(negedge clk);
    chk("t1_c0_s_valid", 32'(bus.s_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t1_c1_s_valid", 32'(bus.s_valid), 32'd1);
    chk("t1_c1_s_addr", bus.s_addr, 32'h0000_0010);
    chk("t1_c1_s_wstrb", 32'(bus.s_wstrb), 32'd0);
    chk("t1_c1_m_ready", 32'(bus.m_ready), 32'd0);
    next_cycle();
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t1_c2_m_ready", 32'(bus.m_ready), 32'b01);
    chk("t1_c2_m_rdata", bus.m_rdata, 32'h1234_5678);
    next_cycle();
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b00;
    @(negedge clk);
    chk("t1_c3_s_valid", 32'(bus.s_valid), 32'd0);
    chk("t1_c3_busy", 32'(busy), 32'd0);
    chk("t1_c3_m_ready", 32'(bus.m_ready), 32'd0);

    // Simultaneous requests after reset: master 0 first, then master 1's write
    next_cycle();
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    bus.m_valid       = 2'b11;
    bus.m_addr[31:0]  = 32'h0000_0020;
    bus.m_wdata[31:0] = 32'h0;
    bus.m_wstrb[3:0]  = 4'h0;
    bus.m_addr[63:32] = 32'h0000_0040;
    bus.m_wdata[63:32] = 32'hA5A5_A5A5;
    bus.m_wstrb[7:4]  = 4'hF;
    xact(0, 32'h0000_0020, 32'h0, 4'h0, 32'h0000_1111, 0, 1'b1);
    xact(1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 32'h0000_2222, 0, 1'b1);

    // Fairness: master 0 keeps requesting, master 1 requests once -> 0,1,0,0
    next_cycle();
    bus.m_valid        = 2'b11;
    bus.m_addr[31:0]   = 32'h0000_0100;
    bus.m_addr[63:32]  = 32'h0000_0200;
    bus.m_wstrb[7:4]   = 4'h0;
    bus.m_wdata[63:32] = 32'h0;
    xact(0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0A01, 0, 1'b0);
    xact(1, 32'h0000_0200, 32'h0, 4'h0, 32'h0000_0B01, 0, 1'b1);
    xact(0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0A02, 0, 1'b0);
    xact(0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0A03, 0, 1'b1);

    // Reset while BUSY with no slave response
    next_cycle();
    bus.m_valid      = 2'b01;
    bus.m_addr[31:0] = 32'h0000_0300;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    next_cycle();
    rstn = 1'b0;
    @(negedge clk);
    chk("rstmid_no_ready", 32'(bus.m_ready), 32'd0);
    next_cycle();
    bus.m_valid = 2'b00;
    @(negedge clk);
    chk("rstmid_s_valid", 32'(bus.s_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_m_ready", 32'(bus.m_ready), 32'd0);
    next_cycle();
    rstn = 1'b1;
    bus.m_valid       = 2'b10;
    bus.m_addr[63:32] = 32'h0000_0400;
    xact(1, 32'h0000_0400, 32'h0, 4'h0, 32'h0000_0C01, 0, 1'b1);

    // Slow slave: response after 5 waiting cycles, outputs held stable
    next_cycle();
    bus.m_valid        = 2'b10;
    bus.m_addr[63:32]  = 32'h0000_0500;
    bus.m_wdata[63:32] = 32'hCAFE_F00D;
    bus.m_wstrb[7:4]   = 4'h3;
    xact(1, 32'h0000_0500, 32'hCAFE_F00D, 4'h3, 32'h0000_0D01, 5, 1'b1);

    // Stray s_ready while IDLE is ignored
    next_cycle();
    bus.s_ready = 1'b1;
    @(negedge clk);
    chk("stray_m_ready", 32'(bus.m_ready), 32'd0);
    next_cycle();
    bus.s_ready = 1'b0;
    @(negedge clk);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_s_valid", 32'(bus.s_valid), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: slave never answers, limit 8
    next_cycle();
    bus.m_valid      = 2'b01;
    bus.m_addr[31:0] = 32'h0000_0600;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      @(negedge clk);
      chk("tmo_wait_s_valid", 32'(bus.s_valid), 32'd1);
      chk("tmo_wait_m_ready", 32'(bus.m_ready), 32'd0);
      chk("tmo_wait_err", 32'(timeout_err), 32'd0);
    end
    next_cycle();
    @(negedge clk);
    chk("tmo_m_ready", 32'(bus.m_ready), 32'b01);
    chk("tmo_m_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    next_cycle();
    bus.m_valid = 2'b00;
    @(negedge clk);
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_s_valid", 32'(bus.s_valid), 32'd0);
    next_cycle();
    bus.m_valid       = 2'b10;
    bus.m_addr[63:32] = 32'h0000_0700;
    bus.m_wdata[63:32] = 32'h0;
    bus.m_wstrb[7:4]  = 4'h0;
    xact(1, 32'h0000_0700, 32'h0, 4'h0, 32'h0000_0E01, 0, 1'b1);
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
